// File: rtl/glyph_string_renderer_if.sv
// Handshake and pixel-output bundle for glyph_string_renderer.
//   master: job requester (drives start/mode/origin/bitmaps/colours, reads status and pixels)
//   slave : the renderer itself
// Signals:
//   start, mode, x, y, glyphs, fg_colour, bg_colour, transparent : job request
//   busy, done                                                  : job status
//   x_out, y_out, colour, writeEn                               : VGA adapter write port
interface glyph_string_renderer_if #(
    parameter int NUM_GLYPHS = 3,
    parameter int GLYPH_W    = 12,
    parameter int GLYPH_H    = 12,
    parameter int X_W        = 8,
    parameter int Y_W        = 7,
    parameter int COLOUR_W   = 3
);
    logic                                  start;
    logic                                  mode;
    logic [X_W-1:0]                        x;
    logic [Y_W-1:0]                        y;
    logic [NUM_GLYPHS*GLYPH_W*GLYPH_H-1:0] glyphs;
    logic [COLOUR_W-1:0]                   fg_colour;
    logic [COLOUR_W-1:0]                   bg_colour;
    logic                                  transparent;
    logic                                  busy;
    logic                                  done;
    logic [X_W-1:0]                        x_out;
    logic [Y_W-1:0]                        y_out;
    logic [COLOUR_W-1:0]                   colour;
    logic                                  writeEn;

    modport master (
        output start, mode, x, y, glyphs, fg_colour, bg_colour, transparent,
        input  busy, done, x_out, y_out, colour, writeEn
    );

    modport slave (
        input  start, mode, x, y, glyphs, fg_colour, bg_colour, transparent,
        output busy, done, x_out, y_out, colour, writeEn
    );
endinterface

// File: rtl/glyph_string_renderer.sv
// glyph_string_renderer
// Draws a string of NUM_GLYPHS monochrome GLYPH_W x GLYPH_H bitmaps at a latched
// origin, or clears the whole screen, emitting one pixel per clock to a VGA
// adapter write port. Pixels falling off the screen are suppressed (writeEn = 0)
// but still take their cycle, so a job always lasts a fixed number of cycles.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; aborts any job without a done pulse
//   bus   : glyph_string_renderer_if.slave (request, status, pixel output)
module glyph_string_renderer #(
    parameter int NUM_GLYPHS = 3,
    parameter int GLYPH_W    = 12,
    parameter int GLYPH_H    = 12,
    parameter int GAP        = 0,
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120,
    parameter int X_W        = 8,
    parameter int Y_W        = 7,
    parameter int COLOUR_W   = 3
) (
    input logic                     clk,
    input logic                     reset,
    glyph_string_renderer_if.slave  bus
);
    localparam int G    = GLYPH_W * GLYPH_H;
    localparam int NB   = NUM_GLYPHS * G;
    localparam int BI_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW   = $clog2(GLYPH_W + 1);
    localparam int RW   = $clog2(GLYPH_H + 1);
    localparam int KW   = $clog2(NUM_GLYPHS + 1);
    localparam int OW   = $clog2(G + 1);
    localparam int PX_W = X_W + 8;
    localparam int PY_W = Y_W + 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAW  = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    // Control state
    logic [1:0]          state;
    logic                drain;
    logic                busy_r, done_r, we_r;
    logic [X_W-1:0]      x_r;
    logic [Y_W-1:0]      y_r;
    logic [COLOUR_W-1:0] colour_r;
    logic [CW-1:0]       col;
    logic [RW-1:0]       row;
    logic [KW-1:0]       gk;
    logic [OW-1:0]       off;         // row*GLYPH_W + col within the current glyph
    logic [BI_W-1:0]     glyph_base;  // bit index of row 0/col 0 of the current glyph
    logic [PX_W-1:0]     kx;          // k*(GLYPH_W+GAP)
    logic [X_W-1:0]      cx;
    logic [Y_W-1:0]      cy;

    // Job data captured at acceptance
    logic [X_W-1:0]      x_l;
    logic [Y_W-1:0]      y_l;
    logic [NB-1:0]       glyphs_l;
    logic [COLOUR_W-1:0] fg_l, bg_l;
    logic                tr_l;

    wire accept = (state == S_IDLE) && bus.start;

    always_ff @(posedge clk) begin
        if (accept) begin
            x_l      <= bus.x;
            y_l      <= bus.y;
            glyphs_l <= bus.glyphs;
            fg_l     <= bus.fg_colour;
            bg_l     <= bus.bg_colour;
            tr_l     <= bus.transparent;
        end
    end

    // Stage p0: pixel addressed by the counters, widened so off-screen
    // coordinates never wrap back onto the visible area
    logic [BI_W-1:0] bit_idx_p0;
    logic            bit_p0, vis_p0, we_p0, draw_last_p0, clear_last_p0;
    logic [PX_W-1:0] px_p0;
    logic [PY_W-1:0] py_p0;

    always_comb begin
        bit_idx_p0    = glyph_base - BI_W'(off);
        bit_p0        = glyphs_l[bit_idx_p0];
        px_p0         = PX_W'(x_l) + kx + PX_W'(col);
        py_p0         = PY_W'(y_l) + PY_W'(row);
        vis_p0        = (px_p0 < PX_W'(SCREEN_W)) && (py_p0 < PY_W'(SCREEN_H));
        we_p0         = (bit_p0 | ~tr_l) & vis_p0;
        draw_last_p0  = (gk == KW'(NUM_GLYPHS - 1)) && (row == RW'(GLYPH_H - 1)) &&
                        (col == CW'(GLYPH_W - 1));
        clear_last_p0 = (cx == X_W'(SCREEN_W - 1)) && (cy == Y_W'(SCREEN_H - 1));
    end

    // Stage p1: registered outputs; drain is the extra busy cycle after the
    // last pixel, ending in the done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            drain      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            we_r       <= 1'b0;
            x_r        <= '0;
            y_r        <= '0;
            colour_r   <= '0;
            col        <= '0;
            row        <= '0;
            gk         <= '0;
            off        <= '0;
            glyph_base <= '0;
            kx         <= '0;
            cx         <= '0;
            cy         <= '0;
        end else begin
            done_r <= 1'b0;
            we_r   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state      <= bus.mode ? S_CLEAR : S_DRAW;
                        busy_r     <= 1'b1;
                        drain      <= 1'b0;
                        col        <= '0;
                        row        <= '0;
                        gk         <= '0;
                        off        <= '0;
                        glyph_base <= BI_W'(G - 1);
                        kx         <= '0;
                        cx         <= '0;
                        cy         <= '0;
                    end
                end
                S_DRAW, S_CLEAR: begin
                    if (drain) begin
                        state  <= S_IDLE;
                        drain  <= 1'b0;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else if (state == S_DRAW) begin
                        x_r      <= px_p0[X_W-1:0];
                        y_r      <= py_p0[Y_W-1:0];
                        colour_r <= bit_p0 ? fg_l : bg_l;
                        we_r     <= we_p0;
                        drain    <= draw_last_p0;
                        if (col == CW'(GLYPH_W - 1)) begin
                            col <= '0;
                            if (row == RW'(GLYPH_H - 1)) begin
                                row        <= '0;
                                off        <= '0;
                                gk         <= gk + 1'b1;
                                glyph_base <= glyph_base + BI_W'(G);
                                kx         <= kx + PX_W'(GLYPH_W + GAP);
                            end else begin
                                row <= row + 1'b1;
                                off <= off + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                            off <= off + 1'b1;
                        end
                    end else begin
                        x_r      <= cx;
                        y_r      <= cy;
                        colour_r <= bg_l;
                        we_r     <= 1'b1;
                        drain    <= clear_last_p0;
                        if (cx == X_W'(SCREEN_W - 1)) begin
                            cx <= '0;
                            cy <= cy + 1'b1;
                        end else begin
                            cx <= cx + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.writeEn = we_r;
    assign bus.x_out   = x_r;
    assign bus.y_out   = y_r;
    assign bus.colour  = colour_r;
endmodule

// File: tb/tb_glyph_string_renderer.sv
module tb_glyph_string_renderer;
    localparam int NG   = 3;
    localparam int GW   = 12;
    localparam int GH   = 12;
    localparam int GAP  = 0;
    localparam int SW   = 160;
    localparam int SH   = 120;
    localparam int G    = GW * GH;
    localparam int NB   = NG * G;
    localparam int PMAX = SW * SH;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    glyph_string_renderer_if bus ();

    glyph_string_renderer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Expected per-pixel stream for the current job
    logic [7:0] exp_x  [0:PMAX-1];
    logic [6:0] exp_y  [0:PMAX-1];
    logic [2:0] exp_c  [0:PMAX-1];
    logic       exp_we [0:PMAX-1];
    int         exp_n;

    // Observations from the last run_job
    int         nw, first_wc, last_wc;
    logic [7:0] fx, lx;
    logic [6:0] fy, ly;
    int         col_bad;  // writes whose colour differs from fg

    logic [NB-1:0] gl;

    task automatic rand_glyphs();
        for (int i = 0; i < NB; i++) gl[i] = 1'($urandom_range(0, 1));
    endtask

    // Reference: walk glyphs/rows/cols and apply the pixel rules directly
    task automatic model_draw(input int x0, input int y0, input logic [NB-1:0] g,
                              input logic [2:0] fg, input logic [2:0] bg, input bit tr);
        int p = 0;
        for (int k = 0; k < NG; k++)
            for (int r = 0; r < GH; r++)
                for (int c = 0; c < GW; c++) begin
                    int  px = x0 + k * (GW + GAP) + c;
                    int  py = y0 + r;
                    bit  s  = g[k * G + G - 1 - (r * GW + c)];
                    exp_x[p]  = 8'(px);
                    exp_y[p]  = 7'(py);
                    exp_c[p]  = s ? fg : bg;
                    exp_we[p] = (s || !tr) && px < SW && py < SH;
                    p++;
                end
        exp_n = p;
    endtask

    task automatic model_clear(input logic [2:0] bg);
        for (int yy = 0; yy < SH; yy++)
            for (int xx = 0; xx < SW; xx++) begin
                exp_x[yy * SW + xx]  = 8'(xx);
                exp_y[yy * SW + xx]  = 7'(yy);
                exp_c[yy * SW + xx]  = bg;
                exp_we[yy * SW + xx] = 1'b1;
            end
        exp_n = SW * SH;
    endtask

    task automatic set_job(input bit md, input int x0, input int y0, input logic [2:0] fg,
                           input logic [2:0] bg, input bit tr);
        bus.mode        = md;
        bus.x           = 8'(x0);
        bus.y           = 7'(y0);
        bus.glyphs      = gl;
        bus.fg_colour   = fg;
        bus.bg_colour   = bg;
        bus.transparent = tr;
        if (md) model_clear(bg);
        else model_draw(x0, y0, gl, fg, bg, tr);
    endtask

    // Caller raises start at a negedge (cycle 0); this walks cycles 1..P+2.
    task automatic run_job(input string name, input bit hold, input int pulse_at);
        int P = exp_n;
        int bad_busy = 0, bad_done = 0, bad_pix = 0, first_bad = -1;
        logic [7:0] ax; logic [6:0] ay; logic [2:0] ac; logic aw;
        nw = 0; first_wc = -1; last_wc = -1; col_bad = 0;
        for (int c = 1; c <= P + 2; c++) begin
            @(negedge clk);
            if (bus.busy !== 1'(c <= P + 1)) bad_busy++;
            if (bus.done !== 1'(c == P + 2)) bad_done++;
            if (c >= 2 && c <= P + 1) begin
                int p = c - 2;
                if (bus.writeEn !== exp_we[p] || bus.x_out !== exp_x[p] ||
                    bus.y_out !== exp_y[p] || bus.colour !== exp_c[p]) begin
                    bad_pix++;
                    if (first_bad < 0) begin
                        first_bad = p; ax = bus.x_out; ay = bus.y_out;
                        ac = bus.colour; aw = bus.writeEn;
                    end
                end
            end else if (bus.writeEn !== 1'b0) bad_pix++;
            if (bus.writeEn === 1'b1) begin
                nw++;
                if (bus.colour !== bus.fg_colour) col_bad++;
                if (first_wc < 0) begin first_wc = c; fx = bus.x_out; fy = bus.y_out; end
                last_wc = c; lx = bus.x_out; ly = bus.y_out;
            end
            if (c == 1 && !hold) bus.start = 1'b0;
            if (c == pulse_at) begin bus.start = 1'b1; bus.x = bus.x + 8'd37; end
            if (c == pulse_at + 1) bus.start = 1'b0;
        end
        n_checks++;
        if (bad_busy != 0) begin
            n_fail++; $display("FAIL %s busy_profile: %0d wrong cycles, required 0", name, bad_busy);
        end
        n_checks++;
        if (bad_done != 0) begin
            n_fail++; $display("FAIL %s done_profile: %0d wrong cycles, required 0", name, bad_done);
        end
        n_checks++;
        if (bad_pix != 0) begin
            n_fail++;
            $display("FAIL %s pixel_stream: %0d bad cycles; first at pixel %0d got (%0d,%0d) c=%0d we=%0d want (%0d,%0d) c=%0d we=%0d",
                     name, bad_pix, first_bad, ax, ay, ac, aw,
                     first_bad >= 0 ? exp_x[first_bad] : 0, first_bad >= 0 ? exp_y[first_bad] : 0,
                     first_bad >= 0 ? exp_c[first_bad] : 0, first_bad >= 0 ? exp_we[first_bad] : 0);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        gl = '0;
        set_job(1'b0, 0, 0, 3'b000, 3'b000, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.writeEn} !== 3'b000 || bus.x_out !== 8'd0 ||
            bus.y_out !== 7'd0 || bus.colour !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_values: busy=%0d done=%0d we=%0d x=%0d y=%0d c=%0d, required all 0",
                     bus.busy, bus.done, bus.writeEn, bus.x_out, bus.y_out, bus.colour);
        end
        // Abort a job mid-stream
        rand_glyphs();
        set_job(1'b0, 40, 50, 3'b111, 3'b110, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (60) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.writeEn} !== 3'b000 || bus.x_out !== 8'd0 ||
            bus.y_out !== 7'd0 || bus.colour !== 3'd0) begin
            n_fail++;
            $display("FAIL midjob_reset: busy=%0d done=%0d we=%0d x=%0d y=%0d c=%0d, required all 0",
                     bus.busy, bus.done, bus.writeEn, bus.x_out, bus.y_out, bus.colour);
        end
        begin
            int dseen = 0;
            repeat (4) begin @(negedge clk); if (bus.done !== 1'b0) dseen++; end
            n_checks++;
            if (dseen != 0) begin
                n_fail++; $display("FAIL reset_no_done: done high %0d cycles, required 0", dseen);
            end
        end
        // Release and start on the very first cycle
        reset = 1'b0;
        rand_glyphs();
        set_job(1'b0, 20, 30, 3'b010, 3'b000, 1'b0);
        bus.start = 1'b1;
        run_job("post_reset", 1'b0, -1);
    endtask

    task automatic test_opaque();
        rand_glyphs();
        set_job(1'b0, 20, 30, 3'b010, 3'b000, 1'b0);
        bus.start = 1'b1;
        run_job("opaque", 1'b0, -1);
        n_checks++;
        if (nw != 432 || first_wc != 2 || last_wc != 433) begin
            n_fail++; $display("FAIL opaque_writes: n=%0d first=%0d last=%0d, required 432/2/433",
                               nw, first_wc, last_wc);
        end
        n_checks++;
        if (fx !== 8'd20 || fy !== 7'd30 || lx !== 8'd55 || ly !== 7'd41) begin
            n_fail++; $display("FAIL opaque_corners: first (%0d,%0d) last (%0d,%0d), required (20,30) (55,41)",
                               fx, fy, lx, ly);
        end
    endtask

    task automatic test_transparent();
        rand_glyphs();
        set_job(1'b0, 20, 30, 3'b010, 3'b000, 1'b1);
        bus.start = 1'b1;
        run_job("transparent", 1'b0, -1);
        n_checks++;
        if (nw != $countones(gl)) begin
            n_fail++; $display("FAIL transp_count: got %0d, required %0d", nw, $countones(gl));
        end
        n_checks++;
        if (col_bad != 0) begin
            n_fail++; $display("FAIL transp_colour: %0d writes not 010, required 0", col_bad);
        end
    endtask

    task automatic test_clipping();
        rand_glyphs();
        set_job(1'b0, 150, 115, 3'b011, 3'b100, 1'b0);
        bus.start = 1'b1;
        run_job("clipping", 1'b0, -1);
        n_checks++;
        if (nw != 50) begin
            n_fail++; $display("FAIL clip_count: got %0d, required 50", nw);
        end
    endtask

    task automatic test_clear();
        rand_glyphs();
        set_job(1'b1, 33, 44, 3'b001, 3'b101, 1'b1);
        bus.start = 1'b1;
        run_job("clear", 1'b0, -1);
        n_checks++;
        if (nw != 19200 || last_wc != 19201 || lx !== 8'd159 || ly !== 7'd119) begin
            n_fail++; $display("FAIL clear_writes: n=%0d last=%0d at (%0d,%0d), required 19200/19201 (159,119)",
                               nw, last_wc, lx, ly);
        end
    endtask

    task automatic test_handshake();
        rand_glyphs();
        set_job(1'b0, 8'($urandom_range(0, 140)), 7'($urandom_range(0, 110)), 3'b110, 3'b001, 1'b0);
        bus.start = 1'b1;
        run_job("ignored_start", 1'b0, 100);
    endtask

    task automatic test_back_to_back();
        rand_glyphs();
        set_job(1'b0, 5, 6, 3'b111, 3'b010, 1'b1);
        bus.start = 1'b1;
        run_job("b2b_first", 1'b1, -1);
        // now mid-cycle P+2 of the first job with start still high: cycle 0 of the next
        rand_glyphs();
        set_job(1'b0, 70, 90, 3'b101, 3'b011, 1'b0);
        run_job("b2b_second", 1'b0, -1);
        n_checks++;
        if (first_wc != 2) begin
            n_fail++; $display("FAIL b2b_first_pixel: cycle %0d after start, required 2", first_wc);
        end
    endtask

    initial begin
        test_reset();
        test_opaque();
        test_transparent();
        test_clipping();
        test_clear();
        test_handshake();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/glyph_string_renderer.md
Name: glyph_string_renderer

Overview:
- Parametrised successor to the fixed three-symbol note drawer.
- Renders a string of NUM_GLYPHS monochrome bitmaps, each GLYPH_W x GLYPH_H, at a caller-supplied origin. Emits one pixel per clock into the VGA adapter write port.
- Adds a start/busy/done handshake, foreground/background colour, transparent or opaque mode, screen-edge clipping, and a full-screen clear mode.
- Sits between the note/octave glyph lookup and the VGA adapter.

Parameters:
- NUM_GLYPHS, 3, number of glyphs per string.
- GLYPH_W, 12, glyph width in pixels.
- GLYPH_H, 12, glyph height in pixels.
- GAP, 0, blank columns between adjacent glyphs.
- SCREEN_W, 160, visible width in pixels.
- SCREEN_H, 120, visible height in pixels.
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- COLOUR_W, 3, colour width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- mode  in  1  0 = draw string, 1 = clear screen.
- x  in  X_W  origin x (left column of glyph 0).
- y  in  Y_W  origin y (top row).
- glyphs  in  NUM_GLYPHS*GLYPH_W*GLYPH_H  flattened bitmaps.
- fg_colour  in  COLOUR_W  colour for set bits.
- bg_colour  in  COLOUR_W  colour for clear bits and for clear mode.
- transparent  in  1  1 = write set bits only.
- busy  out  1  high while a job is in progress.
- done  out  1  one-cycle pulse on job completion.
- x_out  out  X_W  pixel x.
- y_out  out  Y_W  pixel y.
- colour  out  COLOUR_W  pixel colour.
- writeEn  out  1  pixel write strobe.

Behaviour:
- Reset: asserting reset forces state IDLE at any time, including mid-job, with no done pulse. Reset values: busy = 0, done = 0, writeEn = 0, x_out = 0, y_out = 0, colour = 0.
- States: IDLE, DRAW, CLEAR.
- IDLE + start: latch x, y, glyphs, fg_colour, bg_colour, transparent and mode; zero all counters. Go to DRAW if mode = 0, CLEAR if mode = 1.
- start while not in IDLE: ignored.
- Latched inputs: changes to any input after acceptance have no effect on the current job.
- Bitmap layout: G = GLYPH_W*GLYPH_H. Glyph k occupies bits [(k+1)*G-1 : k*G]. Within a glyph, row 0/col 0 is bit k*G+G-1. Order is row-major, descending bit index.
- DRAW scan order: glyph 0..NUM_GLYPHS-1, then row 0..GLYPH_H-1, then col 0..GLYPH_W-1. One pixel per cycle, P = NUM_GLYPHS*G cycles.
- DRAW pixel coordinates: px = x0 + k*(GLYPH_W+GAP) + col; py = y0 + row. Computed at X_W+8 / Y_W+8 bits, no wrap.
- DRAW pixel colour: fg_colour if the bit is set, else bg_colour.
- DRAW writeEn = (bit | ~transparent) & (px < SCREEN_W) & (py < SCREEN_H).
- x_out/y_out carry the low X_W/Y_W bits of px/py whether or not the pixel is clipped.
- Clipped pixels still consume their cycle, so job length is always P.
- CLEAR: scans y 0..SCREEN_H-1, x 0..SCREEN_W-1 (x fastest). colour = bg_colour and writeEn = 1 for all P = SCREEN_W*SCREEN_H pixels.
- Outputs are registered. Cycle 0 is the cycle in which start is accepted:
  - busy = 1 in cycles 1..P+1.
  - Pixel p is presented in cycle p+2.
  - Cycle P+2: done = 1, busy = 0, state IDLE.
- A new start is accepted in cycle P+2.
- Outside pixel cycles writeEn = 0 and x_out/y_out/colour hold their last values.
- Back-to-back jobs: start held high continuously yields one job per P+2 cycles, with no lost or duplicated pixels.

Test Plan:
- Reset check: assert reset mid-stream -> immediately busy = 0, writeEn = 0, x_out = 0, y_out = 0, colour = 0, done stays 0. After release, IDLE accepts start on the first cycle.
- Opaque draw: defaults, x = 20, y = 30, glyphs = {A, sharp, digit 1}, transparent = 0, fg = 3'b010, bg = 3'b000.
  - 432 writes, cycles 2..433.
  - First write at (20,30), last write at (55,41).
  - done pulse in cycle 434.
  - Colour matches each bitmap bit.
- Transparent draw: same stimulus with transparent = 1 -> write count equals popcount(glyphs). Every write has colour 3'b010.
- Clipping: x = 150, y = 115, transparent = 0.
  - Only glyph 0 cols 0..9, rows 0..4 are written: 50 writes.
  - Job still lasts 432 cycles; done in cycle 434.
- Clear mode: mode = 1, bg = 3'b101.
  - 19200 writes, all colour 3'b101.
  - Order (0,0), (1,0) … (159,119).
  - done in cycle 19202.
- Handshake: pulse start again in cycle 100 with a different x -> ignored, first job unchanged. A start held high across cycle 434 begins the second job with its first pixel in cycle 436.
